apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
// - APB3 completer (slave) memory fed by the AHB-to-APB bridge's APB master side.
// - Provides word-addressed storage with configurable wait states and PSLVERR on bad addresses.
// - Serves as the bridge's downstream load for integration and regression.
// PARAMETERS
// - BASE_ADDR    32'h4000_0000  first byte address decoded by this slave
// - DEPTH        256            number of 32-bit words (power of two, 4..4096)
// - WAIT_STATES  2              pready-low cycles inserted in each access phase (0..15)
// PORTS
// - clock    in   1   single clock, all logic on posedge
// - reset    in   1   asynchronous, active-low reset
// - psel     in   1   APB select
// - penable  in   1   APB enable (access phase)
// - pwrite   in   1   1 = write, 0 = read
// - paddr    in   32  byte address
// - pwdata   in   32  write data
// - prdata   out  32  read data, valid when pready=1 and pwrite=0
// - pready   out  1   transfer completion
// - pslverr  out  1   error response, valid only when pready=1
// - err_count out 8   saturating error counter (present only with APB_SLV_ERRCNT_EN)
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, cnt=0, prdata=0, pready=0, pslverr=0, err_count=0.
// - Memory array is not reset; its contents are undefined until written.
// - FSM states: IDLE, ACCESS.
// - IDLE, on psel=1 && penable=0 (setup phase), capture:
//   - pwrite, pwdata, word index = (paddr-BASE_ADDR)>>2;
//   - err_q = (paddr<BASE_ADDR) | (index>=DEPTH) | (paddr[1:0]!=0);
//   - cnt = WAIT_STATES;
//   - prdata = read ? (err_q ? 0 : mem[index]) : prdata (unchanged).
//   - Next state: ACCESS.
// - IDLE, on psel=1 && penable=1 with no preceding setup: protocol error; ignored, no response.
// - ACCESS, psel=1 && penable=1:
//   - cnt!=0: cnt decrements, pready=0.
//   - cnt==0: pready=1, pslverr=err_q, next state IDLE.
//   - Write commit: mem[index]<=pwdata on the pready=1 cycle, only if err_q=0.
// - ACCESS, psel=0: abort; next state IDLE, no write, pready stays 0.
// - pready = (state==ACCESS) & (cnt==0) & psel & penable; pslverr = pready & err_q; both are 0 otherwise.
// - Latency: setup cycle + (WAIT_STATES+1) access cycles; with WAIT_STATES=0, a transfer completes in 2 cycles.
// - Back-to-back: a new setup in the cycle after completion is accepted (state is already IDLE).
// - prdata holds its last value between reads; writes and errored reads do not load mem data.
// - Reset asserted mid-transfer: immediate return to IDLE, pending write dropped.
// CONFIGURATION
// - APB_SLV_ERRCNT_EN defined:
//   - err_count port exists.
//   - It increments on every pready&pslverr cycle and saturates at 8'hFF.
//   - It is cleared only by reset.
// - Undefined: the port and counter logic are absent; all other behaviour is identical.
// TESTING
// - WAIT_STATES=2: write 0xDEADBEEF @0x4000_0010, then read it -> pready high on 3rd access cycle, prdata=0xDEADBEEF, pslverr=0.
// - Read @0x4000_0400 (index 256, out of range) -> pslverr=1 with pready, prdata=0; a later read @0x4000_0000 still returns its prior data.
// - Write @0x4000_0006 (misaligned) -> pslverr=1, and mem[1] is unchanged on readback.
// - Drop psel during the wait phase of a write 0x1234 @0x4000_0020 -> no pready, and mem[8] is unchanged on readback.
// - Reset pulse during ACCESS of a write -> pready=0 and prdata=0 immediately; the write is not committed.
// - APB_SLV_ERRCNT_EN: 300 back-to-back errored reads -> err_count=8'hFF, no wrap; a reset returns it to 0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed memory with fixed wait states and PSLVERR on bad addresses.
// Optional saturating error counter is enabled by defining APB_SLV_ERRCNT_EN.
module apb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
`ifdef APB_SLV_ERRCNT_EN
    output logic [7:0]  err_count,
`endif
    output logic [0:0]  dbg_state
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
    // cycles (psel=1, penable=1); it completes on the cycle where pready=1.
    // Dropping psel during access aborts the transfer without a response.

    logic [31:0] mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   prdata_q, prdata_d;

    logic [29:0]   idx_full;
    logic          addr_err;
    logic          setup;

    assign idx_full = 30'((paddr - BASE_ADDR) >> 2);
    assign addr_err = (paddr < BASE_ADDR) || (idx_full >= 30'(DEPTH)) || (paddr[1:0] != 2'b00);
    assign setup    = psel && !penable;

    assign pready    = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && psel && penable;
    assign pslverr   = pready && err_q;
    assign prdata    = prdata_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        prdata_d = prdata_q;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup is a protocol error and is ignored
                if (setup) begin
                    write_d = pwrite;
                    wdata_d = pwdata;
                    idx_d   = idx_full[AW-1:0];
                    err_d   = addr_err;
                    cnt_d   = WS;
                    if (!pwrite) begin
                        prdata_d = addr_err ? 32'd0 : mem[idx_full[AW-1:0]];
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_d = ST_IDLE;
                end else if (penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            prdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            prdata_q <= prdata_d;
        end
    end

    // Storage is deliberately not reset; a write lands only on its completing cycle.
    always_ff @(posedge clock) begin
        if (pready && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef APB_SLV_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (pslverr && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized and directed bench for apb_slave_mem against a byte-window memory model.
module tb_apb_slave_mem;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam int          DEPTH   = 256;
    localparam int          WS      = 2;
    localparam int          TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [0:0]  dbg_state;
`ifdef APB_SLV_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_known [DEPTH];
    logic [31:0] ref_prdata;
    bit          ref_prdata_known;
    int          ref_errcnt;
    logic [31:0] exp_q [$];

    apb_slave_mem #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset(reset),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
`ifdef APB_SLV_ERRCNT_EN
        .err_count(err_count),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr);
        return (addr < BASE) || (addr >= BASE + 32'(DEPTH * 4)) || (addr[1:0] != 2'b00);
    endfunction

    task automatic bus_idle();
        @(negedge clock);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // One complete transfer; leaves the bus in the access phase so a following
    // call issues its setup in the cycle right after completion.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit          err;
        int          idx;
        int          cycles;
        bit          done;
        logic [31:0] exp;
        err = model_err(addr);
        idx = int'((addr - BASE) >> 2);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clock);
        penable = 1'b1;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < TIMEOUT) begin
            #1;
            cycles++;
            if (pready) done = 1'b1;
            else @(negedge clock);
        end
        check(wr ? "wr_latency" : "rd_latency", 32'(cycles), 32'(WS + 1));
        if (done) begin
            check(wr ? "wr_pslverr" : "rd_pslverr", {31'd0, pslverr}, {31'd0, err});
            if (!wr) begin
                if (err || ref_known[idx]) begin
                    exp_q.push_back(err ? 32'd0 : ref_mem[idx]);
                    exp = exp_q.pop_front();
                    check("rd_data", prdata, exp);
                    ref_prdata = exp;
                    ref_prdata_known = 1'b1;
                end else begin
                    ref_prdata_known = 1'b0;
                end
            end else if (ref_prdata_known) begin
                check("wr_prdata_hold", prdata, ref_prdata);
            end
            if (wr && !err) begin
                ref_mem[idx]   = data;
                ref_known[idx] = 1'b1;
            end
            if (err && ref_errcnt < 255) ref_errcnt++;
        end
        @(posedge clock);
    endtask

    task automatic apb_abort_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clock);
        penable = 1'b1;
        #1 check("abort_wait_pready", {31'd0, pready}, 32'd0);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("abort_pready", {31'd0, pready}, 32'd0);
            @(negedge clock);
        end
    endtask

    task automatic reset_during_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clock);
        penable = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        ref_prdata = 32'd0;
        ref_prdata_known = 1'b1;
        ref_errcnt = 0;
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic enable_without_setup(input logic [31:0] addr);
        @(negedge clock);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = addr; pwdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            #1 check("proto_pready", {31'd0, pready}, 32'd0);
            @(negedge clock);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        bit          wr;

        reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;
        ref_prdata = 32'd0; ref_prdata_known = 1'b1; ref_errcnt = 0;
        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_pready", {31'd0, pready}, 32'd0);
        check("reset_pslverr", {31'd0, pslverr}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
`ifdef APB_SLV_ERRCNT_EN
        check("reset_errcnt", {24'd0, err_count}, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;

        apb_xfer(1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        apb_xfer(1'b0, BASE + 32'h10, 32'd0);
        apb_xfer(1'b1, BASE + 32'h0, 32'hCAFE_0001);
        apb_xfer(1'b0, BASE + 32'h0, 32'd0);
        apb_xfer(1'b0, BASE + 32'h400, 32'd0);
        apb_xfer(1'b0, BASE + 32'h0, 32'd0);
        apb_xfer(1'b1, BASE + 32'h4, 32'h1111_2222);
        apb_xfer(1'b1, BASE + 32'h6, 32'hFFFF_FFFF);
        apb_xfer(1'b0, BASE + 32'h4, 32'd0);
        apb_xfer(1'b1, BASE + 32'h20, 32'h0000_0055);
        bus_idle();
        apb_abort_write(BASE + 32'h20, 32'h0000_1234);
        apb_xfer(1'b0, BASE + 32'h20, 32'd0);
        apb_xfer(1'b1, BASE + 32'h30, 32'hA5A5_5A5A);
        bus_idle();
        reset_during_write(BASE + 32'h30, 32'h0BAD_F00D);
        apb_xfer(1'b0, BASE + 32'h30, 32'd0);
        bus_idle();
        enable_without_setup(BASE + 32'h40);
        apb_xfer(1'b1, BASE + 32'h3FC, 32'h7777_8888);
        apb_xfer(1'b0, BASE + 32'h3FC, 32'd0);
        apb_xfer(1'b0, BASE - 32'd4, 32'd0);
        apb_xfer(1'b1, 32'h0000_0000, 32'h1234_5678);

        for (int i = 0; i < DEPTH; i++) apb_xfer(1'b1, BASE + 32'(i * 4), $urandom);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            case (kind)
                0: addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
                1: addr = BASE - 32'($urandom_range(1, 4096));
                2: addr = BASE + 32'(DEPTH * 4) + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                default: addr = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            apb_xfer(wr, addr, $urandom);
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

`ifdef APB_SLV_ERRCNT_EN
        check("errcnt_model", {24'd0, err_count}, 32'(ref_errcnt));
        for (int n = 0; n < 300; n++) apb_xfer(1'b0, BASE + 32'h400, 32'd0);
        bus_idle();
        #1 check("errcnt_sat", {24'd0, err_count}, 32'h0000_00FF);
        @(negedge clock);
        reset = 1'b0;
        #1 check("errcnt_rst", {24'd0, err_count}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
`endif

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
